ram_true_dp_param: RTL

- Parametrised true dual-port synchronous RAM; next generation of the fixed 1024x32 write-first dual-port RAM in the memory test-case family.
- Adds the following, all sharing one clock:
  - configurable width and depth
  - per-port read-during-write mode
  - byte-lane write enables
  - per-port enables
  - optional output pipeline register
  - deterministic same-address collision handling with a sticky flag
- Used as the generic RAM primitive for memory validation designs and as a BRAM inference target.

---
 rtl/ram_dp_pkg.sv | 28 ++
 rtl/ram_dp_port_out.sv | 67 ++++++
 rtl/ram_true_dp_param.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ram_dp_pkg.sv
// Shared constants and the byte-lane merge helper for the parametrised dual-port RAM.
// The merge works on a fixed maximum width; callers cast their words in and out.
package ram_dp_pkg;

    localparam int RDW_WRITE_FIRST = 0;
    localparam int RDW_READ_FIRST  = 1;
    localparam int RDW_NO_CHANGE   = 2;

    localparam int MAX_DATA_W = 1024;
    localparam int MAX_NB     = MAX_DATA_W / 8;

    // Bytes of din replace bytes of old_word wherever the matching we bit is set.
    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] din,
        input logic [MAX_NB-1:0]     we
    );
        logic [MAX_DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_NB; i++) begin
            if (we[i]) begin
                merged[8*i +: 8] = din[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/ram_dp_port_out.sv
// Per-port read path: read-during-write mode select, no-change hold, valid
// generation and the optional output register stage.
module ram_dp_port_out
    import ram_dp_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MODE    = RDW_WRITE_FIRST,
    parameter int OUT_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              wr,
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] new_word,
    output logic [DATA_W-1:0] dout,
    output logic              valid
);

    logic [DATA_W-1:0] stage1_data;
    logic              stage1_valid;
    logic              hold;
    logic [DATA_W-1:0] read_word;

    assign hold      = wr && (MODE == RDW_NO_CHANGE);
    assign read_word = (wr && (MODE == RDW_WRITE_FIRST)) ? new_word : old_word;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage1_data  <= '0;
            stage1_valid <= 1'b0;
        end else if (en) begin
            if (!hold) begin
                stage1_data  <= read_word;
                stage1_valid <= 1'b1;
            end
        end else begin
            stage1_valid <= 1'b0;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] stage2_data;
            logic              stage2_valid;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    stage2_data  <= '0;
                    stage2_valid <= 1'b0;
                end else begin
                    stage2_data  <= stage1_data;
                    stage2_valid <= stage1_valid;
                end
            end

            assign dout  = stage2_data;
            assign valid = stage2_valid;
        end else begin : g_no_out_reg
            assign dout  = stage1_data;
            assign valid = stage1_valid;
        end
    endgenerate

endmodule

// File: rtl/ram_true_dp_param.sv
// Parametrised true dual-port RAM: memory array, same-address write arbitration
// (port A wins overlapping lanes) and the sticky collision flag.
module ram_true_dp_param
    import ram_dp_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int MODE_A  = RDW_WRITE_FIRST,
    parameter int MODE_B  = RDW_WRITE_FIRST,
    parameter int OUT_REG = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enA,
    input  logic [DATA_W/8-1:0]   weA,
    input  logic [ADDR_W-1:0]     addrA,
    input  logic [DATA_W-1:0]     dinA,
    output logic [DATA_W-1:0]     doutA,
    output logic                  validA,
    input  logic                  enB,
    input  logic [DATA_W/8-1:0]   weB,
    input  logic [ADDR_W-1:0]     addrB,
    input  logic [DATA_W-1:0]     dinB,
    output logic [DATA_W-1:0]     doutB,
    output logic                  validB,
    output logic                  collision,
    input  logic                  coll_clr
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] old_a;
    logic [DATA_W-1:0] old_b;
    logic [DATA_W-1:0] merged_a;
    logic [DATA_W-1:0] merged_b;
    logic [DATA_W-1:0] word_a_mem;
    logic              wr_a;
    logic              wr_b;
    logic              wr_b_mem;
    logic              same_addr;
    logic              coll_now;
    logic              coll_q;

    assign old_a = mem[addrA];
    assign old_b = mem[addrB];

    assign wr_a      = enA && (|weA);
    assign wr_b      = enB && (|weB);
    assign same_addr = enA && enB && (addrA == addrB);
    assign coll_now  = same_addr && (wr_a || wr_b);

    assign merged_a = DATA_W'(byte_merge(MAX_DATA_W'(old_a), MAX_DATA_W'(dinA), MAX_NB'(weA)));
    assign merged_b = DATA_W'(byte_merge(MAX_DATA_W'(old_b), MAX_DATA_W'(dinB), MAX_NB'(weB)));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        word_a_mem = merged_a;
        wr_b_mem   = wr_b;
        // Same-address dual write: one combined write, A's lanes layered over B's.
        if (same_addr && wr_a && wr_b) begin
            word_a_mem = DATA_W'(byte_merge(MAX_DATA_W'(merged_b), MAX_DATA_W'(dinA),
                                            MAX_NB'(weA)));
            wr_b_mem   = 1'b0;
        end
    end

    // NOTE: the array has no reset; clearing it would block RAM inference and
    // its contents must survive rst_n anyway. Only accesses are gated by reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (wr_a) begin
                mem[addrA] <= word_a_mem;
            end
            if (wr_b_mem) begin
                mem[addrB] <= merged_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            coll_q <= 1'b0;
        end else if (coll_now) begin
            coll_q <= 1'b1;
        end else if (coll_clr) begin
            coll_q <= 1'b0;
        end
    end

    assign collision = coll_q;

    ram_dp_port_out #(
        .DATA_W  (DATA_W),
        .MODE    (MODE_A),
        .OUT_REG (OUT_REG)
    ) u_port_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (enA),
        .wr       (wr_a),
        .old_word (old_a),
        .new_word (merged_a),
        .dout     (doutA),
        .valid    (validA)
    );

    ram_dp_port_out #(
        .DATA_W  (DATA_W),
        .MODE    (MODE_B),
        .OUT_REG (OUT_REG)
    ) u_port_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (enB),
        .wr       (wr_b),
        .old_word (old_b),
        .new_word (merged_b),
        .dout     (doutB),
        .valid    (validB)
    );

    // NB is part of the port widths; kept as a named constant for readers.
    logic unused_nb;
    assign unused_nb = (NB > 0);

endmodule
